// File: rtl/draw_rect_ctl.sv
// draw_rect_ctl: rectangle follows the mouse, drops under per-frame gravity on click; define DRAW_RECT_CTL_BOUNCE_EN to bounce on the floor
module draw_rect_ctl #(
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600,
  parameter int RECT_W   = 48,
  parameter int RECT_H   = 64,
  parameter int ACCEL    = 1,
  parameter int VMAX     = 31
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        falling
);
  localparam int XMAX  = SCREEN_W - RECT_W;
  localparam int FLOOR = SCREEN_H - RECT_H;
  typedef enum logic [1:0] {FOLLOW, FALL, LANDED} state_e;
  state_e state_q, state_d;
  logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic signed [7:0] vel_q, vel_d;
  logic left_q, vblnk_q, vblnk_qq;
  logic click, tick;
  logic [11:0] x_clamp, y_clamp;
  logic signed [8:0] v_sum;
  logic signed [7:0] v_new;
  logic signed [12:0] y_new;
`ifdef DRAW_RECT_CTL_BOUNCE_EN
  logic signed [7:0] r;
  assign r = v_new - (v_new >>> 2);
`endif
  assign click   = mouse_left & ~left_q;
  assign tick    = vblnk_q & ~vblnk_qq;
  assign x_clamp = (mouse_xpos > 12'(XMAX)) ? 12'(XMAX) : mouse_xpos;
  assign y_clamp = (mouse_ypos > 12'(FLOOR)) ? 12'(FLOOR) : mouse_ypos;
  assign v_sum   = 9'(vel_q) + 9'(ACCEL);
  assign v_new   = (v_sum > 9'(VMAX)) ? 8'(VMAX) : v_sum[7:0];
  assign y_new   = $signed({1'b0, ypos_q}) + 13'(v_new);
  assign xpos    = xpos_q;
  assign ypos    = ypos_q;
  assign falling = (state_q == FALL);
  // state, position, velocity and edge-detect registers
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q  <= FOLLOW;
      xpos_q   <= '0;
      ypos_q   <= '0;
      vel_q    <= '0;
      left_q   <= 1'b0;
      vblnk_q  <= 1'b0;
      vblnk_qq <= 1'b0;
    end else begin
      state_q  <= state_d;
      xpos_q   <= xpos_d;
      ypos_q   <= ypos_d;
      vel_q    <= vel_d;
      left_q   <= mouse_left;
      vblnk_q  <= vblnk_in;
      vblnk_qq <= vblnk_q;
    end
  end
  // next state: track mouse, apply one gravity step per frame, settle on the floor
  always_comb begin
    state_d = state_q;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;
    vel_d   = vel_q;
    unique case (state_q)
      FOLLOW: begin
        xpos_d = x_clamp;
        ypos_d = y_clamp;
        if (click) begin
          state_d = FALL;
          vel_d   = '0;
        end
      end
      FALL: if (tick) begin
        if (y_new >= 13'(FLOOR)) begin
          ypos_d = 12'(FLOOR);
`ifdef DRAW_RECT_CTL_BOUNCE_EN
          vel_d   = (r >= 2) ? -r : '0;
          state_d = (r >= 2) ? FALL : LANDED;
`else
          vel_d   = '0;
          state_d = LANDED;
`endif
        end else if (y_new[12]) begin
          ypos_d = '0;
          vel_d  = '0;
        end else begin
          ypos_d = y_new[11:0];
          vel_d  = v_new;
        end
      end
      LANDED: begin
        vel_d = '0;
        if (click) state_d = FOLLOW;
      end
      default: state_d = FOLLOW;
    endcase
  end
endmodule

// File: tb/tb_draw_rect_ctl.sv
// tb_draw_rect_ctl: directed checks of follow, gravity, floor, simultaneous click/tick and reset abort
module tb_draw_rect_ctl;
  logic pclk = 1'b0;
  logic rst, vblnk_in, mouse_left, falling;
  logic [11:0] mouse_xpos, mouse_ypos, xpos, ypos;
  int errors = 0, checks = 0;
  int x_land;

  always #5 pclk = ~pclk;

  draw_rect_ctl dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .xpos(xpos), .ypos(ypos), .falling(falling)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic tick_frame();
    vblnk_in = 1'b1;
    step(2);
    vblnk_in = 1'b0;
    step(2);
  endtask

  task automatic do_click();
    mouse_left = 1'b1;
    step(1);
    check("falling_rise", 32'(falling), 1);
    mouse_left = 1'b0;
    step(1);
  endtask

  task automatic set_mouse(input int x, input int y);
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; vblnk_in = 1'b0; mouse_left = 1'b0;
    set_mouse(0, 0);
    step(2);
    rst = 1'b0;
    step(1);
    check("reset_x", 32'(xpos), 0);
    check("reset_fall", 32'(falling), 0);
    set_mouse(900, 700);
    step(1);
    check("clamp_x", 32'(xpos), 752);
    check("clamp_y", 32'(ypos), 536);
    set_mouse(100, 100);
    step(1);
    check("follow_x", 32'(xpos), 100);
    check("follow_y", 32'(ypos), 100);
    set_mouse(200, 50);
    #2;
    check("follow_latency", 32'(xpos), 100);
    step(1);
    check("follow_next", 32'(xpos), 200);
    set_mouse(100, 100);
    step(1);
    do_click();
    set_mouse(300, 300);
    step(1);
    check("fall_x_hold", 32'(xpos), 100);
    check("fall_y_hold", 32'(ypos), 100);
    vblnk_in = 1'b1;
    step(1);
    check("tick_latency", 32'(ypos), 100);
    step(1);
    check("grav_1", 32'(ypos), 101);
    vblnk_in = 1'b0;
    step(2);
    check("one_per_frame", 32'(ypos), 101);
    tick_frame();
    check("grav_2", 32'(ypos), 103);
    tick_frame();
    check("grav_3", 32'(ypos), 106);
    tick_frame();
    check("grav_4", 32'(ypos), 110);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_x", 32'(xpos), 0);
    check("async_rst_y", 32'(ypos), 0);
    check("async_rst_fall", 32'(falling), 0);
    step(1);
    rst = 1'b0;
    set_mouse(60, 70);
    step(1);
    check("rst_follow_x", 32'(xpos), 60);
    check("rst_follow_y", 32'(ypos), 70);
    set_mouse(40, 0);
    step(1);
    do_click();
    for (int i = 0; i < 31; i++) tick_frame();
    check("sat_y31", 32'(ypos), 496);
    check("sat_v31", 32'(dut.vel_q), 31);
    tick_frame();
    check("sat_y32", 32'(ypos), 527);
    check("sat_v32", 32'(dut.vel_q), 31);
`ifdef DRAW_RECT_CTL_BOUNCE_EN
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    set_mouse(10, 330);
    step(1);
    do_click();
    for (int i = 0; i < 19; i++) tick_frame();
    check("bounce_pre", 32'(ypos), 520);
    tick_frame();
    check("bounce_floor", 32'(ypos), 536);
    check("bounce_vel", 32'(dut.vel_q), -15);
    check("bounce_falling", 32'(falling), 1);
    tick_frame();
    check("bounce_up_vel", 32'(dut.vel_q), -14);
    check("bounce_up_y", 32'(ypos), 522);
    for (int i = 0; i < 300 && falling; i++) tick_frame();
    check("bounce_landed", 32'(falling), 0);
    check("bounce_rest_y", 32'(ypos), 536);
    x_land = 10;
`else
    vblnk_in = 1'b1;
    step(2);
    check("floor_y", 32'(ypos), 536);
    check("floor_falling", 32'(falling), 0);
    vblnk_in = 1'b0;
    step(2);
    tick_frame();
    tick_frame();
    check("landed_hold", 32'(ypos), 536);
    x_land = 40;
`endif
    check("landed_vel", 32'(dut.vel_q), 0);
    set_mouse(300, 300);
    vblnk_in = 1'b1;
    step(1);
    mouse_left = 1'b1;
    step(1);
    check("click_tick_y", 32'(ypos), 536);
    check("click_tick_x", 32'(xpos), 32'(x_land));
    check("click_tick_fall", 32'(falling), 0);
    mouse_left = 1'b0;
    vblnk_in = 1'b0;
    step(1);
    check("resume_x", 32'(xpos), 300);
    check("resume_y", 32'(ypos), 300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
